// File: rtl/dup_range_gen.sv
// rtl/dup_range_gen.sv - emits each value of range(base, limit, step) twice over a valid/ready stream
// Optional simulation assertions: define DUP_RANGE_GEN_SVA_EN.
module dup_range_gen (
    input  logic               _clock,
    input  logic               _reset,
    input  logic               _start,
    input  logic               _ready,
    input  logic signed [31:0] base,
    input  logic signed [31:0] limit,
    input  logic signed [31:0] step,
    output logic               _done,
    output logic               _valid,
    output logic signed [31:0] _0
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EMIT_A = 2'd1,
        S_EMIT_B = 2'd2
    } state_t;

    state_t             r_state;
    logic signed [31:0] r_i;
    logic signed [31:0] r_limit;
    logic signed [31:0] r_step;
    logic               r_done;
    logic               r_valid;
    logic signed [31:0] r_out;

    logic        w_start_ok;
    logic [32:0] w_sum;
    logic        w_fits;
    logic        w_next_ok;
    logic        w_fire;

    // A zero step is treated as an empty range so the block can never spin forever.
    function automatic logic in_range(input logic signed [31:0] v,
                                      input logic signed [31:0] l,
                                      input logic signed [31:0] s);
        if (s > 0)
            return v < l;
        else if (s < 0)
            return v > l;
        else
            return 1'b0;
    endfunction

    assign w_start_ok = in_range(base, limit, step);
    assign w_sum      = {r_i[31], r_i} + {r_step[31], r_step};
    assign w_fits     = (w_sum[32] == w_sum[31]);
    assign w_next_ok  = w_fits && in_range(w_sum[31:0], r_limit, r_step);
    assign w_fire     = r_valid && _ready;

    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_limit <= '0;
            r_step  <= '0;
            r_done  <= 1'b1;
            r_valid <= 1'b0;
            r_out   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (_start) begin
                        r_i     <= base;
                        r_limit <= limit;
                        r_step  <= step;
                        if (w_start_ok) begin
                            r_state <= S_EMIT_A;
                            r_valid <= 1'b1;
                            r_done  <= 1'b0;
                            r_out   <= base;
                        end else begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_EMIT_A: begin
                    if (w_fire)
                        r_state <= S_EMIT_B;
                end
                S_EMIT_B: begin
                    if (w_fire) begin
                        // 33-bit sum: leaving the 32-bit range ends iteration instead of wrapping.
                        if (w_next_ok) begin
                            r_i     <= w_sum[31:0];
                            r_out   <= w_sum[31:0];
                            r_state <= S_EMIT_A;
                        end else begin
                            r_state <= S_IDLE;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_done  <= 1'b1;
                end
            endcase
        end
    end

    assign _done  = r_done;
    assign _valid = r_valid;
    assign _0     = r_out;

`ifdef DUP_RANGE_GEN_SVA_EN
    a_hold_stable: assert property (@(posedge _clock) disable iff (!_reset)
        (_valid && !_ready) |=> (_valid && $stable(_0)));
    a_done_valid_excl: assert property (@(posedge _clock) disable iff (!_reset)
        !(_done && _valid));
    a_start_drops_done: assert property (@(posedge _clock) disable iff (!_reset)
        (r_state == S_IDLE && _start && step != 0 && w_start_ok) |=> !_done);
`endif

endmodule

// File: tb/tb_dup_range_gen.sv
// tb/tb_dup_range_gen.sv - directed self-checking bench for dup_range_gen
module tb_dup_range_gen;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               ready;
    logic signed [31:0] base;
    logic signed [31:0] limit;
    logic signed [31:0] step;
    logic               done;
    logic               valid;
    logic signed [31:0] dout;

    int tests = 0;
    int fails = 0;
    int q[$];
    int acc[$];

    dup_range_gen dut (
        ._clock (clk),
        ._reset (rst_n),
        ._start (start),
        ._ready (ready),
        .base   (base),
        .limit  (limit),
        .step   (step),
        ._done  (done),
        ._valid (valid),
        ._0     (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs are scrambled right after the start edge to show they were latched.
    task automatic do_start(input int b, input int l, input int s);
        @(negedge clk);
        base  = b;
        limit = l;
        step  = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        base  = 32'h5A5A_1234;
        limit = 32'h0;
        step  = 32'h0;
    endtask

    task automatic run_full(input string tag, input int b, input int l, input int s, input int exp[$]);
        do_start(b, l, s);
        foreach (exp[k]) begin
            chk($sformatf("%s_valid%0d", tag, k), {31'd0, valid}, 32'd1);
            chk($sformatf("%s_done%0d", tag, k), {31'd0, done}, 32'd0);
            chk($sformatf("%s_data%0d", tag, k), dout, exp[k]);
            tick();
        end
        chk($sformatf("%s_end_done", tag), {31'd0, done}, 32'd1);
        chk($sformatf("%s_end_valid", tag), {31'd0, valid}, 32'd0);
    endtask

    task automatic run_empty(input string tag, input int b, input int l, input int s);
        do_start(b, l, s);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_valid%0d", tag, k), {31'd0, valid}, 32'd0);
            chk($sformatf("%s_done%0d", tag, k), {31'd0, done}, 32'd1);
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        base  = '0;
        limit = '0;
        step  = '0;
        repeat (2) tick();
        chk("rst_done", {31'd0, done}, 32'd1);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_data", dout, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;

        q = '{0, 0, 2, 2, 4, 4, 6, 6, 8, 8};
        run_full("up", 0, 10, 2, q);

        q = '{5, 5, 3, 3, 1, 1};
        run_full("down", 5, 0, -2, q);

        run_empty("empty", 3, 3, 1);
        run_empty("step0", 0, 10, 0);
        chk("retain_data", dout, 32'd1);

        q = '{32'h7FFF_FFFE, 32'h7FFF_FFFE};
        run_full("ovf", 32'h7FFF_FFFE, 32'h7FFF_FFFF, 5, q);

        // Backpressure: ready goes low on the first cycle and then pseudo-randomly.
        ready = 1'b0;
        acc.delete();
        do_start(0, 4, 1);
        for (int c = 0; c < 200 && !done; c++) begin
            logic [31:0] held;
            ready = (c == 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
            #1;
            chk($sformatf("bp_excl%0d", c), {31'd0, done && valid}, 32'd0);
            held = dout;
            if (valid && ready)
                acc.push_back(dout);
            if (valid && !ready) begin
                tick();
                chk($sformatf("bp_hold_valid%0d", c), {31'd0, valid}, 32'd1);
                chk($sformatf("bp_hold_data%0d", c), dout, held);
            end else begin
                tick();
            end
        end
        chk("bp_done", {31'd0, done}, 32'd1);
        chk("bp_count", acc.size(), 32'd8);
        q = '{0, 0, 1, 1, 2, 2, 3, 3};
        foreach (q[k])
            chk($sformatf("bp_acc%0d", k), (k < acc.size()) ? acc[k] : 32'hFFFF_FFFF, q[k]);

        // Asynchronous reset after the third output has been accepted.
        ready = 1'b1;
        do_start(0, 10, 2);
        tick();
        tick();
        chk("mid_before", dout, 32'd2);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, valid}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd1);
        chk("mid_rst_data", dout, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        q = '{1, 1, 2, 2};
        run_full("restart", 1, 3, 1, q);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dup_range_gen.md
# dup_range_gen

Hardware generator equivalent to the Python generator `for i in range(base, limit, step): yield i; yield i`. It emits every element of the integer range twice, back-to-back, as a stream of signed 32-bit values under a valid/ready handshake. It sits in the func_call family of generated blocks and is driven by a parent FSM or bench that pulses `_start` and consumes results.

## Interface
Parameters:
- none (all widths fixed at 32 bits).

Ports. Module name is `dup_range_gen`.
- `_clock`  in  1  sole clock, rising-edge active.
- `_reset`  in  1  reset, asynchronous and active-low.
- `_start`  in  1  sampled only in IDLE; latches `base`, `limit`, `step` and begins iteration.
- `_ready`  in  1  consumer accepts `_0` on a rising edge where `_valid && _ready`.
- `base`  in  32 signed  first range value; only meaningful while `_start` is high.
- `limit`  in  32 signed  exclusive bound.
- `step`  in  32 signed  increment; may be negative.
- `_done`  out  1  high when idle or finished.
- `_valid`  out  1  `_0` holds an output element.
- `_0`  out  32 signed  current output value.

## Operation
- States: IDLE, EMIT_A (first copy of i), EMIT_B (second copy of i).
- Reset: state=IDLE, `_done`=1, `_valid`=0, `_0`=0, internal i/limit/step registers=0.
- IDLE and `_start`=1: latch inputs and set i=base.
  - If the range is non-empty, go to EMIT_A with `_valid`=1, `_0`=base, `_done`=0.
  - If the range is empty, stay in IDLE with `_done`=1 and `_valid`=0.
- Range non-empty test for element i: step>0 requires i<limit; step<0 requires i>limit; step==0 is always treated as empty (no output, no hang).
- EMIT_A with handshake: go to EMIT_B; `_0` unchanged (duplicate).
- EMIT_B with handshake: compute n=i+step in 33-bit signed arithmetic.
  - If n is in range and representable in 32 bits: i=n, go to EMIT_A, `_0`=n.
  - Otherwise go to IDLE with `_valid`=0 and `_done`=1. Overflow never wraps; it terminates.
- No handshake (`_ready`=0 while valid): state, `_valid` and `_0` hold stable.
- `_start` outside IDLE is ignored. Inputs are not sampled after the start edge.
- `_0` retains its last value in IDLE. Consumers qualify it with `_valid`.

## Timing
- `_start` sampled on edge N: `_valid`/`_done` updated on edge N itself (registered), visible before edge N+1. First element is accepted at the earliest on edge N+1.
- With `_ready` held high, one element per cycle; a range of k elements yields 2k outputs on consecutive edges, and `_done` rises on the edge accepting the last output.
- `_done` and `_valid` are never high simultaneously.
- Asynchronous reset mid-stream aborts immediately to reset values; a new `_start` is accepted on the first edge after release.
- All outputs are driven directly from registers.

## Configuration
- `DUP_RANGE_GEN_SVA_EN` defined: compiles in simulation assertions:
  - `_0` and `_valid` stay stable while `_valid && !_ready`.
  - `_done && _valid` never occurs.
  - `_start` in IDLE with step≠0 and a non-empty range drops `_done` on the next edge.
- Undefined: no assertions; RTL behaviour is identical.

## Test plan
- base=0, limit=10, step=2, `_ready`=1 -> outputs 0,0,2,2,4,4,6,6,8,8 on 10 consecutive cycles, then `_done`=1, `_valid`=0.
- base=5, limit=0, step=-2 -> 5,5,3,3,1,1 then done.
- Empty/degenerate: (3,3,1) and (0,10,0) -> no `_valid` pulse, `_done` stays 1.
- Backpressure: (0,4,1) with `_ready` toggling pseudo-randomly -> accepted sequence is exactly 0,0,1,1,2,2,3,3, and outputs are held while `_ready`=0.
- Overflow: base=0x7FFFFFFE, limit=0x7FFFFFFF, step=5 -> 0x7FFFFFFE twice then done, no wrap.
- Reset asserted after the third output of (0,10,2) -> `_valid`=0 and `_done`=1 immediately; a restart with (1,3,1) yields 1,1,2,2.
